// File: rtl/reset_sequencer_if.sv
// Board and MMIO side of the reset sequencer: request inputs, reset outputs and status.
// The slave modport is the sequencer's view; master is the board/SoC side that drives the requests.
interface reset_sequencer_if;
    logic       button_in;
    logic       sw_reset_req;
    logic       wdt_expire;
    logic       mem_init_done;
    logic       periph_reset_n;
    logic       cpu_reset_n;
    logic [3:0] reset_cause;
    logic       mem_timeout;
    logic       busy;

    modport master (
        output button_in, sw_reset_req, wdt_expire, mem_init_done,
        input  periph_reset_n, cpu_reset_n, reset_cause, mem_timeout, busy
    );

    modport slave (
        input  button_in, sw_reset_req, wdt_expire, mem_init_done,
        output periph_reset_n, cpu_reset_n, reset_cause, mem_timeout, busy
    );
endinterface

// File: rtl/reset_sequencer.sv
// Sequences the peripheral/memory domain and then the CPU out of reset, and records
// the cause of the last reset for firmware.
module reset_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 64,
    parameter int MEM_TIMEOUT     = 1024,
    parameter int GAP_CYCLES      = 8
) (
    input  logic              clk,
    input  logic              reset,
    reset_sequencer_if.slave  bus
);

    localparam int MAX_HM  = (HOLD_CYCLES > MEM_TIMEOUT) ? HOLD_CYCLES : MEM_TIMEOUT;
    localparam int MAX_CYC = (MAX_HM > GAP_CYCLES) ? MAX_HM : GAP_CYCLES;
    localparam int CW      = $clog2(MAX_CYC);
    localparam int DW      = $clog2(DEBOUNCE_CYCLES);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] MEM_LAST  = CW'(MEM_TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        HOLD,
        WAIT_MEM,
        GAP,
        RUN
    } state_t;

    state_t        state;
    logic [CW-1:0] counter;
    logic          btn_meta;
    logic          btn_sync;
    logic [DW-1:0] deb_cnt;
    logic          btn_req;
    logic          req;
    logic [3:0]    cause_bits;
    logic          periph_reset_n_q;
    logic          cpu_reset_n_q;
    logic [3:0]    reset_cause_q;
    logic          mem_timeout_q;
    logic          busy_q;

    // The button is asynchronous: synchronize it, then require it to stay high
    // for DEBOUNCE_CYCLES consecutive cycles before it counts as a press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
            deb_cnt  <= '0;
        end else begin
            btn_meta <= bus.button_in;
            btn_sync <= btn_meta;
            if (!btn_sync) begin
                deb_cnt <= '0;
            end else if (deb_cnt != DEB_LAST) begin
                deb_cnt <= deb_cnt + DW'(1);
            end
        end
    end

    assign btn_req    = btn_sync && (deb_cnt == DEB_LAST);
    assign req        = btn_req | bus.sw_reset_req | bus.wdt_expire;
    assign cause_bits = {bus.wdt_expire, bus.sw_reset_req, btn_req, 1'b0};

    // Outputs are set alongside the state they belong to, so each one is a plain
    // register that changes on the same edge as the state transition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= HOLD;
            counter          <= '0;
            periph_reset_n_q <= 1'b0;
            cpu_reset_n_q    <= 1'b0;
            reset_cause_q    <= 4'b0001;
            mem_timeout_q    <= 1'b0;
            busy_q           <= 1'b1;
        end else if (req) begin
            // Requests arriving during HOLD accumulate; a fresh event replaces the old cause.
            state            <= HOLD;
            counter          <= '0;
            periph_reset_n_q <= 1'b0;
            cpu_reset_n_q    <= 1'b0;
            mem_timeout_q    <= 1'b0;
            busy_q           <= 1'b1;
            if (state == HOLD) begin
                reset_cause_q <= reset_cause_q | cause_bits;
            end else begin
                reset_cause_q <= cause_bits;
            end
        end else begin
            case (state)
                HOLD: begin
                    if (counter == HOLD_LAST) begin
                        state            <= WAIT_MEM;
                        counter          <= '0;
                        periph_reset_n_q <= 1'b1;
                    end else begin
                        counter <= counter + CW'(1);
                    end
                end
                WAIT_MEM: begin
                    if (bus.mem_init_done) begin
                        state   <= GAP;
                        counter <= '0;
                    end else if (counter == MEM_LAST) begin
                        state         <= GAP;
                        counter       <= '0;
                        mem_timeout_q <= 1'b1;
                    end else begin
                        counter <= counter + CW'(1);
                    end
                end
                GAP: begin
                    if (counter == GAP_LAST) begin
                        state         <= RUN;
                        counter       <= '0;
                        cpu_reset_n_q <= 1'b1;
                        busy_q        <= 1'b0;
                    end else begin
                        counter <= counter + CW'(1);
                    end
                end
                default: begin
                    counter <= '0;
                end
            endcase
        end
    end

    assign bus.periph_reset_n = periph_reset_n_q;
    assign bus.cpu_reset_n    = cpu_reset_n_q;
    assign bus.reset_cause    = reset_cause_q;
    assign bus.mem_timeout    = mem_timeout_q;
    assign bus.busy           = busy_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a timestamp-based model of the release schedule checked every
// cycle, directed scenarios with literal expectations, then a randomized request phase.
module tb_reset_sequencer;

    localparam int DEB  = 16;
    localparam int HOLD = 64;
    localparam int MEMT = 1024;
    localparam int GAP  = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    reset_sequencer_if bus_if ();

    reset_sequencer #(
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HOLD),
        .MEM_TIMEOUT    (MEMT),
        .GAP_CYCLES     (GAP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Model state: timestamps (in rising-edge numbers) rather than a state machine.
    int         edge_num;
    int         seq_start;
    int         wait_exit;
    int         last_low_prev;
    int         last_low_cur;
    logic [3:0] m_cause;
    logic       m_tmo;
    logic       m_breq;
    logic       m_req;
    logic       m_was_hold;
    logic       m_periph;
    logic       m_cpu;
    int         k;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h (edge %0d)", name, actual, expected, edge_num);
        end
    endtask

    task automatic modelReset();
        edge_num      = 0;
        seq_start     = 0;
        wait_exit     = -1;
        last_low_prev = 0;
        last_low_cur  = 0;
        m_cause       = 4'b0001;
        m_tmo         = 1'b0;
    endtask

    // A press is recognised once DEB consecutive samples are high, seen two edges late
    // because of the synchronizer; the schedule then follows from the last request edge.
    always @(posedge clk) begin
        if (reset) begin
            modelReset();
        end else begin
            edge_num++;
            m_breq     = (last_low_prev <= edge_num - 2 - DEB);
            m_req      = m_breq | bus_if.sw_reset_req | bus_if.wdt_expire;
            m_was_hold = (edge_num - 1 - seq_start) < HOLD;
            if (m_req) begin
                if (m_was_hold) begin
                    m_cause = m_cause | {bus_if.wdt_expire, bus_if.sw_reset_req, m_breq, 1'b0};
                end else begin
                    m_cause = {bus_if.wdt_expire, bus_if.sw_reset_req, m_breq, 1'b0};
                end
                seq_start = edge_num;
                wait_exit = -1;
                m_tmo     = 1'b0;
            end else if (wait_exit < 0 && (edge_num - seq_start) > HOLD) begin
                if (bus_if.mem_init_done) begin
                    wait_exit = edge_num;
                end else if ((edge_num - seq_start) == HOLD + MEMT) begin
                    wait_exit = edge_num;
                    m_tmo     = 1'b1;
                end
            end
            last_low_prev = last_low_cur;
            if (!bus_if.button_in) last_low_cur = edge_num;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            m_periph = (edge_num - seq_start) >= HOLD;
            m_cpu    = (wait_exit >= 0) && (edge_num >= wait_exit + GAP);
            checkOutput("cycle",
                32'({bus_if.periph_reset_n, bus_if.cpu_reset_n, bus_if.reset_cause,
                     bus_if.mem_timeout, bus_if.busy}),
                32'({m_periph, m_cpu, m_cause, m_tmo, !m_cpu}));
        end
    end

    task automatic gotoEdge(input int n);
        while (edge_num < n) @(negedge clk);
    endtask

    task automatic pulseSw();
        bus_if.sw_reset_req = 1'b1;
        @(negedge clk);
        bus_if.sw_reset_req = 1'b0;
    endtask

    task automatic waitRun();
        for (int i = 0; i < 3000; i++) begin
            if (bus_if.busy === 1'b0) return;
            @(negedge clk);
        end
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL wait_run: busy still %b after 3000 cycles, expected 0", bus_if.busy);
    endtask

    task automatic applyStimulus();
        int btn_left;
        btn_left = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            bus_if.sw_reset_req = ($urandom_range(0, 299) == 0);
            bus_if.wdt_expire   = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 49) == 0) bus_if.mem_init_done = ~bus_if.mem_init_done;
            if (btn_left > 0) begin
                btn_left--;
                bus_if.button_in = 1'b1;
            end else begin
                bus_if.button_in = 1'b0;
                if ($urandom_range(0, 199) == 0) btn_left = int'($urandom_range(3, 30));
            end
        end
        @(negedge clk);
        bus_if.sw_reset_req  = 1'b0;
        bus_if.wdt_expire    = 1'b0;
        bus_if.button_in     = 1'b0;
        bus_if.mem_init_done = 1'b1;
    endtask

    initial begin
        bus_if.button_in     = 1'b0;
        bus_if.sw_reset_req  = 1'b0;
        bus_if.wdt_expire    = 1'b0;
        bus_if.mem_init_done = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Power-up release schedule
        gotoEdge(HOLD - 1);
        checkOutput("pwr_periph_before", 32'(bus_if.periph_reset_n), 32'h0);
        gotoEdge(HOLD);
        checkOutput("pwr_periph_rise", 32'(bus_if.periph_reset_n), 32'h1);
        gotoEdge(72);
        checkOutput("pwr_cpu_before", 32'(bus_if.cpu_reset_n), 32'h0);
        gotoEdge(73);
        checkOutput("pwr_cpu_rise", 32'(bus_if.cpu_reset_n), 32'h1);
        checkOutput("pwr_busy", 32'(bus_if.busy), 32'h0);
        checkOutput("pwr_cause", 32'(bus_if.reset_cause), 32'h1);
        checkOutput("pwr_tmo", 32'(bus_if.mem_timeout), 32'h0);

        // Memory never reports done: CPU released on timeout
        bus_if.mem_init_done = 1'b0;
        k = edge_num + 1;
        pulseSw();
        checkOutput("sw_cause", 32'(bus_if.reset_cause), 32'h4);
        gotoEdge(k + HOLD + MEMT + GAP - 1);
        checkOutput("tmo_cpu_before", 32'(bus_if.cpu_reset_n), 32'h0);
        gotoEdge(k + HOLD + MEMT + GAP);
        checkOutput("tmo_cpu_rise", 32'(bus_if.cpu_reset_n), 32'h1);
        checkOutput("tmo_flag", 32'(bus_if.mem_timeout), 32'h1);
        bus_if.mem_init_done = 1'b1;
        pulseSw();
        checkOutput("tmo_cleared", 32'(bus_if.mem_timeout), 32'h0);

        // Short button pulse ignored, long press resets
        waitRun();
        bus_if.button_in = 1'b1;
        repeat (10) @(negedge clk);
        bus_if.button_in = 1'b0;
        repeat (30) @(negedge clk);
        checkOutput("btn_short_ignored", 32'(bus_if.busy), 32'h0);
        bus_if.button_in = 1'b1;
        repeat (40) @(negedge clk);
        bus_if.button_in = 1'b0;
        checkOutput("btn_cause", 32'(bus_if.reset_cause), 32'h2);
        checkOutput("btn_periph", 32'(bus_if.periph_reset_n), 32'h0);

        // Simultaneous software and watchdog requests
        waitRun();
        bus_if.sw_reset_req = 1'b1;
        bus_if.wdt_expire   = 1'b1;
        @(negedge clk);
        bus_if.sw_reset_req = 1'b0;
        bus_if.wdt_expire   = 1'b0;
        checkOutput("sw_wdt_cause", 32'(bus_if.reset_cause), 32'hC);

        // Request during GAP restarts the hold
        waitRun();
        k = edge_num + 1;
        pulseSw();
        gotoEdge(k + 69);
        checkOutput("gap_periph", 32'(bus_if.periph_reset_n), 32'h1);
        checkOutput("gap_cpu", 32'(bus_if.cpu_reset_n), 32'h0);
        pulseSw();
        checkOutput("gap_req_cause", 32'(bus_if.reset_cause), 32'h4);
        checkOutput("gap_req_periph", 32'(bus_if.periph_reset_n), 32'h0);
        gotoEdge(k + 70 + HOLD - 1);
        checkOutput("gap_rehold_before", 32'(bus_if.periph_reset_n), 32'h0);
        gotoEdge(k + 70 + HOLD);
        checkOutput("gap_rehold_rise", 32'(bus_if.periph_reset_n), 32'h1);

        waitRun();
        applyStimulus();
        waitRun();

        // Asynchronous reset in the middle of WAIT_MEM
        bus_if.mem_init_done = 1'b0;
        k = edge_num + 1;
        pulseSw();
        gotoEdge(k + HOLD + 6);
        #3 reset = 1'b1;
        #1;
        checkOutput("async_periph", 32'(bus_if.periph_reset_n), 32'h0);
        checkOutput("async_cpu", 32'(bus_if.cpu_reset_n), 32'h0);
        checkOutput("async_cause", 32'(bus_if.reset_cause), 32'h1);
        checkOutput("async_tmo", 32'(bus_if.mem_timeout), 32'h0);
        checkOutput("async_busy", 32'(bus_if.busy), 32'h1);
        repeat (2) @(negedge clk);
        bus_if.mem_init_done = 1'b1;
        reset = 1'b0;
        gotoEdge(HOLD);
        checkOutput("after_async_periph", 32'(bus_if.periph_reset_n), 32'h1);
        gotoEdge(HOLD + 1 + GAP);
        checkOutput("after_async_cpu", 32'(bus_if.cpu_reset_n), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
